can_reg_write_demux: RTL and testbench

- Parametrised successor to the fixed-map CAN register demux. Sits between the host controller bus and the CAN core register-fetch interface.
- Per controller request, it runs a request/ack handshake to the CAN core and captures the returned word into one of NUM_REGS word-aligned shadow registers.
- Added over the previous generation:
  - explicit FSM
  - address range/alignment error response
  - ack timeout
  - per-register write strobes
  - self-clearing registers

---
 rtl/can_reg_write_demux.sv | 142 ++++++++++++++
 tb/tb_can_reg_write_demux.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/can_reg_write_demux.sv
// Controller-to-CAN register fetch demux: request/ack to the CAN core, reply captured into NUM_REGS shadow regs.
// One cycle each way (CS->DEMUX2Can_CS, Can ack->controller ack); controller holds CS until ack and must drop it before the next request.
module can_reg_write_demux #(
    parameter int                  DATA_W        = 32,
    parameter int                  ADDR_W        = 8,
    parameter int                  NUM_REGS      = 36,
    parameter int                  TIMEOUT       = 16,
    parameter logic [NUM_REGS-1:0] SELF_CLR_MASK = '0
) (
    input  logic                       sys_clk,
    input  logic                       IP2Can_reset_n,
    input  logic                       Controller2DEMUX_CS,
    input  logic [ADDR_W-1:0]          addr_bus,
    input  logic [DATA_W-1:0]          Can2DEMUX_data,
    input  logic                       Can2DEMUX_ack,
    output logic                       DEMUX2Can_CS,
    output logic [ADDR_W-1:0]          DEMUX2Can_addr,
    output logic                       DEMUX2Controller_ack,
    output logic                       DEMUX2Controller_err,
    output logic [NUM_REGS*DATA_W-1:0] DEMUX2reg_bus,
    output logic [NUM_REGS-1:0]        DEMUX2reg_wr_strobe,
    output logic                       busy
);
    localparam int TW_RAW = $clog2(TIMEOUT + 1);
    localparam int TW     = (TW_RAW < 1) ? 1 : TW_RAW;
    localparam int IW     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP, ST_HOLD} state_t;

    state_t                            state_q, state_d;
    logic [IW-1:0]                     idx_q, idx_d;
    logic                              can_cs_q, can_cs_d;
    logic [ADDR_W-1:0]                 can_addr_q, can_addr_d;
    logic                              ack_q, ack_d;
    logic                              err_q, err_d;
    logic [TW-1:0]                     timer_q, timer_d;
    logic [NUM_REGS-1:0]               strobe_q, strobe_d;
    logic [NUM_REGS-1:0][DATA_W-1:0]   regs_q, regs_d;

    logic [ADDR_W-1:0] word_idx;
    logic              addr_bad;

    assign word_idx = addr_bus >> 2;
    assign addr_bad = (addr_bus[1:0] != 2'b00) || (32'(word_idx) >= NUM_REGS);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        can_cs_d   = can_cs_q;
        can_addr_d = can_addr_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        timer_d    = timer_q;
        strobe_d   = '0;
        regs_d     = regs_q;

        // The strobe from last cycle marks the register just written; masked ones clear now.
        for (int i = 0; i < NUM_REGS; i++) begin
            if (strobe_q[i] && SELF_CLR_MASK[i]) begin
                regs_d[i] = '0;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (Controller2DEMUX_CS) begin
                    if (addr_bad) begin
                        ack_d   = 1'b1;
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        idx_d      = IW'(word_idx);
                        can_addr_d = addr_bus;
                        can_cs_d   = 1'b1;
                        timer_d    = '0;
                        state_d    = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (Can2DEMUX_ack) begin
                    regs_d[idx_q]   = Can2DEMUX_data;
                    strobe_d[idx_q] = 1'b1;
                    can_cs_d        = 1'b0;
                    ack_d           = 1'b1;
                    state_d         = ST_RESP;
                end else if ((TIMEOUT != 0) && (timer_q == T_LAST)) begin
                    can_cs_d = 1'b0;
                    ack_d    = 1'b1;
                    err_d    = 1'b1;
                    state_d  = ST_RESP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_RESP: begin
                state_d = Controller2DEMUX_CS ? ST_HOLD : ST_IDLE;
            end
            ST_HOLD: begin
                // A long CS must fall before another request is accepted.
                if (!Controller2DEMUX_CS) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge IP2Can_reset_n) begin
        if (!IP2Can_reset_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            can_cs_q   <= 1'b0;
            can_addr_q <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            timer_q    <= '0;
            strobe_q   <= '0;
            regs_q     <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            can_cs_q   <= can_cs_d;
            can_addr_q <= can_addr_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            timer_q    <= timer_d;
            strobe_q   <= strobe_d;
            regs_q     <= regs_d;
        end
    end

    assign DEMUX2Can_CS         = can_cs_q;
    assign DEMUX2Can_addr       = can_addr_q;
    assign DEMUX2Controller_ack = ack_q;
    assign DEMUX2Controller_err = err_q;
    assign DEMUX2reg_bus        = regs_q;
    assign DEMUX2reg_wr_strobe  = strobe_q;
    assign busy                 = (state_q != ST_IDLE);

endmodule

// File: tb/tb_can_reg_write_demux.sv
// Scoreboard bench for can_reg_write_demux: expected controller responses queued at request time, popped on ack.
module tb_can_reg_write_demux;
    localparam int DW = 32;
    localparam int AW = 8;
    localparam int NR = 36;
    localparam logic [NR-1:0] SCM = 36'h1;

    logic            sys_clk;
    logic            rst_n;
    logic            cs;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   can_data;
    logic            can_ack;
    logic            can_cs;
    logic [AW-1:0]   can_addr;
    logic            ack;
    logic            err;
    logic [NR*DW-1:0] reg_bus;
    logic [NR-1:0]   strobe;
    logic            busy;

    can_reg_write_demux #(
        .DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .TIMEOUT(16), .SELF_CLR_MASK(SCM)
    ) dut (
        .sys_clk(sys_clk),
        .IP2Can_reset_n(rst_n),
        .Controller2DEMUX_CS(cs),
        .addr_bus(addr),
        .Can2DEMUX_data(can_data),
        .Can2DEMUX_ack(can_ack),
        .DEMUX2Can_CS(can_cs),
        .DEMUX2Can_addr(can_addr),
        .DEMUX2Controller_ack(ack),
        .DEMUX2Controller_err(err),
        .DEMUX2reg_bus(reg_bus),
        .DEMUX2reg_wr_strobe(strobe),
        .busy(busy)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic        err;
        int          idx;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] exp_regs [NR];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          rises   = 0;
    logic        cs_prev = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < NR; i++) begin
            chk($sformatf("%s_reg%0d", tag, i), 64'(reg_bus[i*DW +: DW]), 64'(exp_regs[i]));
        end
    endtask

    // Response monitor and DEMUX2Can_CS request counter
    always @(negedge sys_clk) begin
        if (can_cs && !cs_prev) rises++;
        cs_prev = can_cs;
        if (rst_n && ack) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", 64'(ack), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("ack_err", 64'(err), 64'(e.err));
                if (!e.err) begin
                    chk("wr_strobe", 64'(strobe), 64'(36'h1 << e.idx));
                    chk("wr_data", 64'(reg_bus[e.idx*DW +: DW]), 64'(e.data));
                    exp_regs[e.idx] = SCM[e.idx] ? 32'h0 : e.data;
                end else begin
                    chk("err_strobe", 64'(strobe), 64'd0);
                end
            end
        end
    end

    // ack_after: WAIT-state edge (1..16) on which the CAN core acks; <=0 or >16 means never.
    task automatic req(input logic [7:0] a, input int ack_after, input logic [31:0] d,
                       input int hold, input bit spur);
        exp_t e;
        bit   bad;
        bit   done;
        int   r0;
        bad    = (a[1:0] != 2'b00) || ((a >> 2) >= NR);
        e.idx  = int'(a >> 2);
        e.data = d;
        e.err  = bad || (ack_after < 1) || (ack_after > 16);
        @(posedge sys_clk); #1;
        cs = 1'b1; addr = a; r0 = rises;
        sb.push_back(e);
        @(posedge sys_clk); #1;
        if (bad) begin
            chk("bad_no_can_cs", 64'(can_cs), 64'd0);
        end else begin
            chk("can_cs_latency", 64'(can_cs), 64'd1);
            chk("can_addr", 64'(can_addr), 64'(a));
            done = 1'b0;
            for (int k = 1; k <= 16 && !done; k++) begin
                if (k == ack_after) begin can_ack = 1'b1; can_data = d; end
                @(posedge sys_clk); #1;
                can_ack = 1'b0;
                if (k == 15 && e.err) chk("wait_cs_at_15", 64'(can_cs), 64'd1);
                if (k == ack_after || k == 16) done = 1'b1;
            end
            chk("can_cs_dropped", 64'(can_cs), 64'd0);
        end
        for (int h = 0; h < hold; h++) begin
            if (spur) begin can_ack = 1'b1; can_data = 32'hDEAD_BEEF; end
            @(posedge sys_clk); #1;
            can_ack = 1'b0;
        end
        if (hold > 0) chk("busy_in_hold", 64'(busy), 64'd1);
        cs = 1'b0;
        @(posedge sys_clk); #1;
        chk("idle_after_cs_low", 64'(busy), 64'd0);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        chk("can_cs_requests", 64'(rises - r0), bad ? 64'd0 : 64'd1);
        check_all("regs");
    endtask

    initial begin
        rst_n = 1'b0; cs = 1'b0; addr = '0; can_data = '0; can_ack = 1'b0;
        for (int i = 0; i < NR; i++) exp_regs[i] = 32'h0;
        #12;
        chk("rst_can_cs", 64'(can_cs), 64'd0);
        chk("rst_ack", 64'(ack), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_strobe", 64'(strobe), 64'd0);
        check_all("rst");
        @(posedge sys_clk); #1;
        rst_n = 1'b1;

        req(8'h08, 3, 32'h0000_01F4, 2, 1'b0);
        req(8'h06, 0, 32'h0, 0, 1'b0);
        req(8'h90, 0, 32'h0, 1, 1'b0);
        req(8'h30, 0, 32'h1234_5678, 0, 1'b0);
        req(8'h30, 16, 32'hCAFE_0030, 0, 1'b0);
        req(8'h00, 1, 32'h0000_0001, 0, 1'b0);
        req(8'h10, 2, 32'hA5A5_0010, 10, 1'b1);
        req(8'h8C, 1, 32'hFFFF_FFFF, 0, 1'b0);

        // Reset in the middle of WAIT, between clock edges
        @(posedge sys_clk); #1;
        cs = 1'b1; addr = 8'h14;
        @(posedge sys_clk); #1;
        cs = 1'b0;
        repeat (3) @(posedge sys_clk);
        #3; rst_n = 1'b0; #1;
        for (int i = 0; i < NR; i++) exp_regs[i] = 32'h0;
        chk("arst_can_cs", 64'(can_cs), 64'd0);
        chk("arst_can_addr", 64'(can_addr), 64'd0);
        chk("arst_ack", 64'(ack), 64'd0);
        chk("arst_err", 64'(err), 64'd0);
        chk("arst_strobe", 64'(strobe), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        check_all("arst");
        #2; rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge sys_clk); #1;
            can_ack = 1'b1; can_data = 32'h5555_AAAA;
            @(posedge sys_clk); #1;
            can_ack = 1'b0;
            chk("post_rst_ack", 64'(ack), 64'd0);
            chk("post_rst_busy", 64'(busy), 64'd0);
        end
        check_all("post_rst");
        chk("sb_final", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish got=running exp=done");
        $fatal(1, "watchdog");
    end

endmodule
